// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the dual-clock FIFO slice: the reset-sequencer state
// encoding and the default sequencer timing constants.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Reset sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ASSERT   = 3'd1,
        WAIT_LOW = 3'd2,
        RELEASE  = 3'd3,
        DONE     = 3'd4
    } rst_seq_state_t;

    // Default number of clk cycles the FIFO reset is held low.
    localparam int RST_HOLD_CYC    = 8;
    // Default acknowledge wait limit (timeout build only).
    localparam int RST_TIMEOUT_CYC = 1024;
    // Default sequencer counter width.
    localparam int RST_CNT_W       = 11;

endpackage : fifo_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic single-bit two-flop level synchronizer with a configurable reset
// value. Reusable for any slow level crossing into the clk_i domain.
//
// Ports:
//   clk_i  in  1  destination clock
//   rst_i  in  1  synchronous, active-high reset (loads RST_VAL)
//   d_i    in  1  asynchronous level input
//   q_o    out 1  synchronized level, two clk_i cycles after d_i changes
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous level; first stage may go metastable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/fifo_rst_seq.sv
// -----------------------------------------------------------------------------
// fifo_rst_seq
// Single-clock reset sequencer for the dual-clock FIFO. Asserts fifo_rst_n,
// holds it for HOLD_CYC cycles, waits until both FIFO domains report reset,
// releases it, waits until both domains report out of reset, then pulses
// rst_done. Power-up (and any rst) runs a full sequence automatically.
//
// Optional feature macro: FIFO_RST_SEQ_TIMEOUT_EN
//   Defined   : acknowledge waits are bounded by TIMEOUT_CYC; on expiry the
//               sequence retries from ASSERT and sticky rst_err is raised.
//   Undefined : acknowledge waits are unbounded and rst_err does not exist.
//
// Ports:
//   clk          in  1  system clock
//   rst          in  1  synchronous, active-high reset
//   rst_req      in  1  single-cycle request, accepted only in IDLE
//   wr_rst_n_in  in  1  write-domain synchronized reset level (async to clk)
//   rd_rst_n_in  in  1  read-domain synchronized reset level (async to clk)
//   fifo_rst_n   out 1  registered active-low FIFO reset
//   rst_busy     out 1  registered, high whenever state != IDLE
//   rst_done     out 1  registered single-cycle completion pulse
//   rst_err      out 1  sticky timeout flag (timeout build only)
// -----------------------------------------------------------------------------
module fifo_rst_seq
    import fifo_pkg::*;
#(
    parameter int HOLD_CYC    = RST_HOLD_CYC,
    parameter int TIMEOUT_CYC = RST_TIMEOUT_CYC,
    parameter int CNT_W       = RST_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_req,
    input  logic wr_rst_n_in,
    input  logic rd_rst_n_in,
    output logic fifo_rst_n,
    output logic rst_busy,
    output logic rst_done
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
    ,
    output logic rst_err
`endif
);

    // Reject parameter sets whose counter cannot reach its terminal counts.
    if ((HOLD_CYC < 32'sd1) || (CNT_W < 32'sd1) || (CNT_W > 32'sd30) ||
        ((32'sd1 <<< CNT_W) <= HOLD_CYC) || ((32'sd1 <<< CNT_W) <= TIMEOUT_CYC)) begin : g_bad_params
        $error("fifo_rst_seq: invalid HOLD_CYC/TIMEOUT_CYC/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 32'sd1);
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 32'sd1);
`endif

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    rst_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fifo_rst_n_q, fifo_rst_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_s, rd_s;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
    logic             err_q, err_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync_wr (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (wr_rst_n_in),
        .q_o   (wr_s)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rd (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rd_rst_n_in),
        .q_o   (rd_s)
    );

    // Next-state, counter and output decode; outputs derive from state_d so
    // the registered outputs line up with the registered state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (rst_req) begin
                    state_d = ASSERT;
                end else begin
                    state_d = IDLE;
                end
            end
            ASSERT: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = WAIT_LOW;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
            end
            WAIT_LOW: begin
                if (!wr_s && !rd_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = RELEASE;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = ASSERT;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
`else
                end else begin
                    cnt_d   = CNT_ZERO;
                end
`endif
            end
            RELEASE: begin
                if (wr_s && rd_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = DONE;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = ASSERT;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                end
`else
                end else begin
                    cnt_d   = CNT_ZERO;
                end
`endif
            end
            DONE: begin
                // A request landing here is dropped on purpose: only IDLE accepts.
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
            default: begin
                // Unused encodings recover through a fresh, reset-asserted sequence.
                cnt_d   = CNT_ZERO;
                state_d = ASSERT;
            end
        endcase

        fifo_rst_n_d = !((state_d == ASSERT) || (state_d == WAIT_LOW));
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    // State and output registers; rst lands in ASSERT with the FIFO reset low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ASSERT;
            cnt_q        <= CNT_ZERO;
            fifo_rst_n_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fifo_rst_n_q <= fifo_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign fifo_rst_n = fifo_rst_n_q;
    assign rst_busy   = busy_q;
    assign rst_done   = done_q;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
    assign rst_err    = err_q;
`endif

endmodule : fifo_rst_seq

// File: tb/tb_fifo_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_fifo_rst_seq
// Directed/randomized bench for fifo_rst_seq. The FIFO domains are modelled
// as delay lines echoing fifo_rst_n after dw/dr cycles. Expected waveforms
// come from a timeline computed per sequence:
//   a = first cycle with reset asserted, D = max(dw, dr)
//   r = a + max(HOLD, 2 + D) + 1   (first cycle fifo_rst_n is high again)
//   d = r + 3 + D                  (the rst_done cycle; busy through d)
// Timeout cases are built only with FIFO_RST_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_fifo_rst_seq;

    localparam int H   = 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    logic rst_req;
    logic wr_in;
    logic rd_in;
    logic fifo_rst_n;
    logic rst_busy;
    logic rst_done;
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
    logic rst_err;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   dw     = 4;
    int   dr     = 4;
    bit   force_rd_hi = 1'b0;
    bit   force_wr_lo = 1'b0;
    logic exp_err = 1'b0;
    bit   hist [0:8191];

    always #5 clk = ~clk;

    fifo_rst_seq #(.HOLD_CYC(H), .TIMEOUT_CYC(TMO), .CNT_W(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_req     (rst_req),
        .wr_rst_n_in (wr_in),
        .rd_rst_n_in (rd_in),
        .fifo_rst_n  (fifo_rst_n),
        .rst_busy    (rst_busy),
        .rst_done    (rst_done)
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
        ,
        .rst_err     (rst_err)
`endif
    );

    // Value of fifo_rst_n recorded at cycle idx (treated as high before time).
    function automatic bit past_f(input int idx);
        if (idx < 0 || idx > 8191) return 1'b1;
        return hist[idx];
    endfunction

    // Advance one clock, sample outputs #1 after the edge, drive the acks.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (cyc <= 8191) hist[cyc] = (fifo_rst_n === 1'b0) ? 1'b0 : 1'b1;
        wr_in = force_wr_lo ? 1'b0 : past_f(cyc - dw);
        rd_in = force_rd_hi ? 1'b1 : past_f(cyc - dr);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Compare all outputs of the current cycle against the sequence timeline.
    task automatic chk_cycle(input string ph, input int r, input int d);
        chk({ph, "_fifo_rst_n"}, fifo_rst_n, (cyc >= r) ? 1'b1 : 1'b0);
        chk({ph, "_busy"},       rst_busy,   (cyc <= d) ? 1'b1 : 1'b0);
        chk({ph, "_done"},       rst_done,   (cyc == d) ? 1'b1 : 1'b0);
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
        chk({ph, "_err"},        rst_err,    exp_err);
`endif
    endtask

    task automatic idle(input string ph, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk({ph, "_idle_rst_n"}, fifo_rst_n, 1'b1);
            chk({ph, "_idle_busy"},  rst_busy,   1'b0);
            chk({ph, "_idle_done"},  rst_done,   1'b0);
        end
    endtask

    // One requested sequence; optional ignored requests and a mid-RELEASE rst.
    task automatic run_seq(input string ph, input int new_dw, input int new_dr,
                           input bit pulses, input bit mid_rst);
        int a, r, d, dm;
        bit aborted;
        aborted = 1'b0;
        dw = new_dw;
        dr = new_dr;
        dm = (dw > dr) ? dw : dr;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        a = cyc;
        r = a + ((H > 2 + dm) ? H : 2 + dm) + 1;
        d = r + 3 + dm;
        while (cyc <= d + 1) begin
            chk_cycle(ph, r, d);
            if (cyc == d + 1) break;
            if (pulses && (cyc == a + 2 || cyc == r + 1 || cyc == d)) rst_req = 1'b1;
            if (mid_rst && !aborted && cyc == r + 1) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end
            step();
            rst_req = 1'b0;
            if (rst) begin
                rst = 1'b0;
                a   = cyc;
                r   = a + ((H > 2 + dm) ? H : 2 + dm) + 1;
                d   = r + 3 + dm;
            end
        end
    endtask

    initial begin
        int lows, dones;
        bit seen_high, finished;
        rst     = 1'b1;
        rst_req = 1'b0;
        wr_in   = 1'b1;
        rd_in   = 1'b1;

        // Reset values while rst is high.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rst_n", fifo_rst_n, 1'b0);
            chk("rst_busy",  rst_busy,   1'b1);
            chk("rst_done",  rst_done,   1'b0);
`ifdef FIFO_RST_SEQ_TIMEOUT_EN
            chk("rst_err",   rst_err,    1'b0);
`endif
        end

        // Power-up sequence runs on its own, bounded by a cycle budget.
        rst = 1'b0;
        lows = 0; dones = 0; seen_high = 1'b0; finished = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            step();
            if (!seen_high) begin
                if (fifo_rst_n === 1'b0) lows++;
                else seen_high = 1'b1;
            end
            if (rst_done === 1'b1) dones++;
            if (rst_busy === 1'b0) finished = 1'b1;
        end
        chk("pu_finished",    logic'(finished),   1'b1);
        chk("pu_low_ge_hold", logic'(lows >= H),  1'b1);
        chk("pu_one_done",    logic'(dones == 1), 1'b1);
        chk("pu_rst_n_high",  fifo_rst_n,         1'b1);

        // Randomized requests from IDLE with random ack latencies.
        for (int i = 0; i < 6; i++) begin
            idle("rnd", int'($urandom_range(4, 1)));
            run_seq("rnd", int'($urandom_range(6, 1)), int'($urandom_range(6, 1)), 1'b0, 1'b0);
        end

        // Skewed acknowledges in both directions.
        idle("skew", 30);
        run_seq("skew_rd", 3, 23, 1'b0, 1'b0);
        idle("skew", 30);
        run_seq("skew_wr", 22, 2, 1'b0, 1'b0);
        idle("skew", 30);

        // Requests while busy and in DONE are ignored.
        run_seq("busy_req", int'($urandom_range(5, 1)), int'($urandom_range(5, 1)), 1'b1, 1'b0);
        idle("busy_req", 3);

        // rst during RELEASE restarts the whole sequence.
        run_seq("mid_rst", 3, 4, 1'b0, 1'b1);
        idle("mid_rst", 3);

        // Acknowledge activity while IDLE has no effect.
        force_wr_lo = 1'b1;
        idle("idle_ack", 6);
        force_wr_lo = 1'b0;
        idle("idle_ack", 6);

`ifdef FIFO_RST_SEQ_TIMEOUT_EN
        begin
            int a, r, d;
            dw = 2;
            dr = 2;
            force_rd_hi = 1'b1;
            rst_req = 1'b1;
            step();
            rst_req = 1'b0;
            a = cyc;
            // 16 WAIT_LOW cycles from a+8 time out at a+24, retry holds 8 more.
            r = a + 24 + H + 1;
            d = r + 3 + 2;
            while (cyc <= d + 1) begin
                exp_err = (cyc >= a + 24) ? 1'b1 : 1'b0;
                chk_cycle("tmo", r, d);
                if (cyc == d + 1) break;
                if (cyc == a + 26) force_rd_hi = 1'b0;
                step();
            end
            idle("tmo", 4);
            chk("tmo_err_sticky", rst_err, 1'b1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_rst_seq
